// File: rtl/spi_reg_bank.sv
// SPI mode-0 peripheral register bank: 1+ADDR_W+DATA_W bit frames, MSB-first, writes commit one clk after the last sclk rise.
// Define SPI_REG_BANK_READBACK_EN to return register contents on cipo for read frames (R/W = 0).
module spi_reg_bank #(
  parameter int NUM_REGS = 5,
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 7
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         sclk,
  input  logic                         ncs,
  input  logic                         copi,
  output logic                         cipo,
  output logic                         cipo_oe,
  output logic [NUM_REGS*DATA_W-1:0]   regs_flat,
  output logic                         wr_strobe,
  output logic [ADDR_W-1:0]            wr_addr,
  output logic                         frame_err
);

  localparam int FRAME_W = 1 + ADDR_W + DATA_W;
  localparam int CNT_W   = $clog2(FRAME_W + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_W - 1);

  // Bit [0] is the metastability stage, [1] the synchronised value, [2] its previous value for edge detection.
  logic [2:0] sclk_q, sclk_d;
  logic [2:0] ncs_q, ncs_d;
  logic [1:0] copi_q, copi_d;

  logic                        active_q, active_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic [FRAME_W-2:0]          shift_q, shift_d;
  logic [NUM_REGS*DATA_W-1:0]  regs_q, regs_d;
  logic                        wr_strobe_q, wr_strobe_d;
  logic [ADDR_W-1:0]           wr_addr_q, wr_addr_d;
  logic                        frame_err_q, frame_err_d;

  logic               sclk_rise, ncs_fall, ncs_rise;
  logic [FRAME_W-1:0] frame;
  logic [ADDR_W-1:0]  frame_addr;

  assign sclk_rise  = sclk_q[1] & ~sclk_q[2];
  assign ncs_fall   = ~ncs_q[1] & ncs_q[2];
  assign ncs_rise   = ncs_q[1] & ~ncs_q[2];
  assign frame      = {shift_q, copi_q[1]};
  assign frame_addr = frame[DATA_W +: ADDR_W];

`ifdef SPI_REG_BANK_READBACK_EN
  localparam logic [CNT_W-1:0] CNT_HDR  = CNT_W'(ADDR_W);
  localparam logic [CNT_W-1:0] CNT_DATA = CNT_W'(ADDR_W + 1);

  logic              sclk_fall;
  logic [ADDR_W:0]   hdr;
  logic              rd_vld_q, rd_vld_d;
  logic [DATA_W-1:0] rd_sh_q, rd_sh_d;
  logic              cipo_q, cipo_d;

  assign sclk_fall = ~sclk_q[1] & sclk_q[2];
  assign hdr       = {shift_q[ADDR_W-1:0], copi_q[1]};
`endif

  always_comb begin
    sclk_d      = {sclk_q[1:0], sclk};
    ncs_d       = {ncs_q[1:0], ncs};
    copi_d      = {copi_q[0], copi};
    active_d    = active_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    regs_d      = regs_q;
    wr_strobe_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    frame_err_d = 1'b0;

    // Deassertion wins over a coincident final sclk rise, so a late ncs release always discards the frame.
    if (ncs_rise) begin
      frame_err_d = active_q && (cnt_q != '0) && (cnt_q != CNT_FULL);
      active_d    = 1'b0;
    end else if (ncs_fall) begin
      active_d = 1'b1;
      cnt_d    = '0;
      shift_d  = '0;
    end else if (active_q && sclk_rise && (cnt_q != CNT_FULL)) begin
      cnt_d   = cnt_q + CNT_W'(1);
      shift_d = frame[FRAME_W-2:0];
      if ((cnt_q == CNT_LAST) && frame[FRAME_W-1]) begin
        for (int i = 0; i < NUM_REGS; i++) begin
          if (frame_addr == ADDR_W'(i)) begin
            regs_d[i*DATA_W +: DATA_W] = frame[DATA_W-1:0];
            wr_strobe_d                = 1'b1;
            wr_addr_d                  = frame_addr;
          end
        end
      end
    end

`ifdef SPI_REG_BANK_READBACK_EN
    rd_vld_d = rd_vld_q;
    rd_sh_d  = rd_sh_q;
    cipo_d   = cipo_q;
    if (ncs_rise || ncs_fall || !active_q) begin
      rd_vld_d = 1'b0;
      cipo_d   = 1'b0;
    end else if (sclk_rise && (cnt_q == CNT_HDR)) begin
      rd_vld_d = 1'b0;
      rd_sh_d  = '0;
      if (!hdr[ADDR_W]) begin
        for (int i = 0; i < NUM_REGS; i++) begin
          if (hdr[ADDR_W-1:0] == ADDR_W'(i)) begin
            rd_vld_d = 1'b1;
            rd_sh_d  = regs_q[i*DATA_W +: DATA_W];
          end
        end
      end
    end else if (sclk_fall) begin
      // Falls between the last address rise and the final data rise present the next data bit.
      if (rd_vld_q && (cnt_q >= CNT_DATA) && (cnt_q != CNT_FULL)) begin
        cipo_d  = rd_sh_q[DATA_W-1];
        rd_sh_d = rd_sh_q << 1;
      end else begin
        cipo_d = 1'b0;
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_q      <= '0;
      ncs_q       <= '0;
      copi_q      <= '0;
      active_q    <= 1'b0;
      cnt_q       <= '0;
      shift_q     <= '0;
      regs_q      <= '0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
      frame_err_q <= 1'b0;
    end else begin
      sclk_q      <= sclk_d;
      ncs_q       <= ncs_d;
      copi_q      <= copi_d;
      active_q    <= active_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      regs_q      <= regs_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
      frame_err_q <= frame_err_d;
    end
  end

`ifdef SPI_REG_BANK_READBACK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_vld_q <= 1'b0;
      rd_sh_q  <= '0;
      cipo_q   <= 1'b0;
    end else begin
      rd_vld_q <= rd_vld_d;
      rd_sh_q  <= rd_sh_d;
      cipo_q   <= cipo_d;
    end
  end

  assign cipo    = cipo_q;
  assign cipo_oe = active_q;
`else
  assign cipo    = 1'b0;
  assign cipo_oe = 1'b0;
`endif

  assign regs_flat = regs_q;
  assign wr_strobe = wr_strobe_q;
  assign wr_addr   = wr_addr_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_spi_reg_bank.sv
// Directed bench for spi_reg_bank at default parameters; expectations follow SPI_REG_BANK_READBACK_EN.
module tb_spi_reg_bank;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        sclk  = 1'b0;
  logic        ncs   = 1'b1;
  logic        copi  = 1'b0;
  logic        cipo, cipo_oe, wr_strobe, frame_err;
  logic [39:0] regs_flat;
  logic [6:0]  wr_addr;

  int          checks     = 0;
  int          errors     = 0;
  int          strobe_cnt = 0;
  int          ferr_cnt   = 0;
  logic [6:0]  last_addr  = '0;
  logic [15:0] rx;
  logic        oe_seen;
  int          s0, f0;

  always #5 clk = ~clk;

  spi_reg_bank dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sclk      (sclk),
    .ncs       (ncs),
    .copi      (copi),
    .cipo      (cipo),
    .cipo_oe   (cipo_oe),
    .regs_flat (regs_flat),
    .wr_strobe (wr_strobe),
    .wr_addr   (wr_addr),
    .frame_err (frame_err)
  );

  always @(negedge clk) begin
    if (wr_strobe) begin
      strobe_cnt++;
      last_addr = wr_addr;
    end
    if (frame_err) ferr_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic spi_bits(input logic [15:0] f, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      copi = (i < 16) ? f[15-i] : 1'b0;
      repeat (4) @(negedge clk);
      if (i < 16) rx[15-i] = cipo;
      if (cipo_oe) oe_seen = 1'b1;
      sclk = 1'b1;
      repeat (4) @(negedge clk);
      sclk = 1'b0;
    end
  endtask

  task automatic spi_frame(input logic [15:0] f, input int nbits);
    rx      = '0;
    oe_seen = 1'b0;
    ncs     = 1'b0;
    repeat (6) @(negedge clk);
    spi_bits(f, nbits);
    repeat (6) @(negedge clk);
    ncs  = 1'b1;
    copi = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  initial begin
    repeat (4) @(negedge clk);
    check("rst_regs", 64'(regs_flat), 64'h0);
    check("rst_strobe", 64'(wr_strobe), 64'h0);
    check("rst_addr", 64'(wr_addr), 64'h0);
    check("rst_ferr", 64'(frame_err), 64'h0);
    check("rst_cipo", 64'(cipo), 64'h0);
    check("rst_oe", 64'(cipo_oe), 64'h0);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);

    s0 = strobe_cnt; f0 = ferr_cnt;
    spi_frame(16'h8455, 16);
    check("wr4_regs", 64'(regs_flat), 64'h55_00_00_00_00);
    check("wr4_strobes", 64'(strobe_cnt - s0), 64'd1);
    check("wr4_addr", 64'(last_addr), 64'd4);
    check("wr4_ferr", 64'(ferr_cnt - f0), 64'd0);

    s0 = strobe_cnt;
    spi_frame(16'h80F0, 16);
    spi_frame(16'h81A5, 16);
    check("wr01_low16", 64'(regs_flat[15:0]), 64'hA5F0);
    check("wr01_strobes", 64'(strobe_cnt - s0), 64'd2);

    s0 = strobe_cnt;
    spi_frame(16'h8712, 16);
    check("oob_regs", 64'(regs_flat), 64'h55_00_00_A5_F0);
    check("oob_strobes", 64'(strobe_cnt - s0), 64'd0);

    s0 = strobe_cnt; f0 = ferr_cnt;
    spi_frame(16'h8033, 9);
    check("short_ferr", 64'(ferr_cnt - f0), 64'd1);
    check("short_regs", 64'(regs_flat), 64'h55_00_00_A5_F0);
    check("short_strobes", 64'(strobe_cnt - s0), 64'd0);

    s0 = strobe_cnt; f0 = ferr_cnt;
    spi_frame(16'h8033, 20);
    check("long_regs", 64'(regs_flat), 64'h55_00_00_A5_33);
    check("long_strobes", 64'(strobe_cnt - s0), 64'd1);
    check("long_ferr", 64'(ferr_cnt - f0), 64'd0);

    ncs = 1'b0;
    repeat (6) @(negedge clk);
    spi_bits(16'h8201, 8);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("midrst_regs", 64'(regs_flat), 64'h0);
    check("midrst_strobe", 64'(wr_strobe), 64'h0);
    check("midrst_addr", 64'(wr_addr), 64'h0);
    check("midrst_ferr", 64'(frame_err), 64'h0);
    check("midrst_cipo", 64'(cipo), 64'h0);
    check("midrst_oe", 64'(cipo_oe), 64'h0);
    s0 = strobe_cnt; f0 = ferr_cnt;
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    spi_bits(16'hFFFF, 10);
    repeat (6) @(negedge clk);
    ncs = 1'b1;
    repeat (8) @(negedge clk);
    check("stale_regs", 64'(regs_flat), 64'h0);
    check("stale_ferr", 64'(ferr_cnt - f0), 64'd0);
    check("stale_strobes", 64'(strobe_cnt - s0), 64'd0);

    spi_frame(16'h8201, 16);
    check("wr2_regs", 64'(regs_flat), 64'h00_00_01_00_00);
    check("wr2_addr", 64'(last_addr), 64'd2);

    spi_frame(16'h83C3, 16);
    check("wr3_regs", 64'(regs_flat), 64'h00_C3_01_00_00);
    s0 = strobe_cnt;
    spi_frame(16'h0300, 16);
    check("rd3_regs", 64'(regs_flat), 64'h00_C3_01_00_00);
    check("rd3_strobes", 64'(strobe_cnt - s0), 64'd0);
`ifdef SPI_REG_BANK_READBACK_EN
    check("rd3_cipo", 64'(rx), 64'h00C3);
    check("rd3_oe", 64'(oe_seen), 64'd1);
`else
    check("rd3_cipo", 64'(rx), 64'h0000);
    check("rd3_oe", 64'(oe_seen), 64'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
